// File: rtl/decode_in_capture_fifo.sv
// Capture FIFO for LC-3 decode-stage instructions: filters by opcode mask, queues
// {instr, npc} pairs and presents the decoded head record to a consumer.
module decode_in_capture_fifo #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_decode,
    input  logic [15:0]                dout,
    input  logic [PC_W-1:0]            npc_in,
    input  logic [15:0]                opcode_mask,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [15:0]                out_instr,
    output logic [PC_W-1:0]            out_npc,
    output logic [3:0]                 out_opcode,
    output logic [2:0]                 out_dr,
    output logic [2:0]                 out_sr1,
    output logic [2:0]                 out_sr2,
    output logic [2:0]                 out_baser,
    output logic [4:0]                 out_imm5,
    output logic [8:0]                 out_pcoffset9,
    output logic [5:0]                 out_pcoffset6,
    output logic [2:0]                 out_nzp,
    output logic                       out_middle_bit,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] npc_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            capture;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [15:0]     head_instr;
    logic [PC_W-1:0] head_npc;

    assign capture   = enable_decode && opcode_mask[dout[15:12]];
    assign full      = (level == LW'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the capture.
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (!push && pop)
                level <= level - LW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != {CNT_W{1'b1}})
                    drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever level is 0.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            instr_mem[wr_ptr] <= dout;
            npc_mem[wr_ptr]   <= npc_in;
        end
    end

    assign head_instr = instr_mem[rd_ptr];
    assign head_npc   = npc_mem[rd_ptr];

    always_comb begin
        out_instr      = '0;
        out_npc        = '0;
        out_opcode     = '0;
        out_dr         = '0;
        out_sr1        = '0;
        out_sr2        = '0;
        out_baser      = '0;
        out_imm5       = '0;
        out_pcoffset9  = '0;
        out_pcoffset6  = '0;
        out_nzp        = '0;
        out_middle_bit = 1'b0;
        if (out_valid) begin
            out_instr  = head_instr;
            out_npc    = head_npc;
            out_opcode = head_instr[15:12];
            case (head_instr[15:12])
                4'b0001, 4'b0101: begin
                    out_dr  = head_instr[11:9];
                    out_sr1 = head_instr[8:6];
                    if (head_instr[5]) begin
                        out_imm5       = head_instr[4:0];
                        out_middle_bit = 1'b1;
                    end else begin
                        out_sr2 = head_instr[2:0];
                    end
                end
                4'b1001: begin
                    out_dr  = head_instr[11:9];
                    out_sr1 = head_instr[8:6];
                end
                4'b0010, 4'b1010, 4'b1110: begin
                    out_dr        = head_instr[11:9];
                    out_pcoffset9 = head_instr[8:0];
                end
                4'b0110: begin
                    out_dr        = head_instr[11:9];
                    out_baser     = head_instr[8:6];
                    out_pcoffset6 = head_instr[5:0];
                end
                4'b0111: begin
                    out_sr1       = head_instr[11:9];
                    out_baser     = head_instr[8:6];
                    out_pcoffset6 = head_instr[5:0];
                end
                4'b0011, 4'b1011: begin
                    out_sr1       = head_instr[11:9];
                    out_pcoffset9 = head_instr[8:0];
                end
                4'b1100: begin
                    out_baser = head_instr[8:6];
                end
                4'b0000: begin
                    out_nzp       = head_instr[11:9];
                    out_pcoffset9 = head_instr[8:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_in_capture_fifo.sv
// Directed bench for decode_in_capture_fifo: decode table plus sequences for
// overflow, concurrent push/pop, masking, clear and asynchronous reset.
module tb_decode_in_capture_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] opcode_mask;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_npc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dr, out_sr1, out_sr2, out_baser, out_nzp;
    logic [4:0]  out_imm5;
    logic [8:0]  out_pcoffset9;
    logic [5:0]  out_pcoffset6;
    logic        out_middle_bit;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    decode_in_capture_fifo #(.PC_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode), .dout(dout),
        .npc_in(npc_in), .opcode_mask(opcode_mask), .clear(clear), .out_ready(out_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_npc(out_npc),
        .out_opcode(out_opcode), .out_dr(out_dr), .out_sr1(out_sr1), .out_sr2(out_sr2),
        .out_baser(out_baser), .out_imm5(out_imm5), .out_pcoffset9(out_pcoffset9),
        .out_pcoffset6(out_pcoffset6), .out_nzp(out_nzp), .out_middle_bit(out_middle_bit),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] dout;
        logic [15:0] npc;
        logic [3:0]  op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  baser;
        logic [4:0]  imm5;
        logic [8:0]  off9;
        logic [5:0]  off6;
        logic [2:0]  nzp;
        logic        mb;
    } dec_vec_t;

    dec_vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cap(input logic [15:0] d, input logic [15:0] n);
        enable_decode = 1'b1;
        dout = d;
        npc_in = n;
        tick();
        enable_decode = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [2:0] lv, input logic ov,
                              input logic [7:0] dc);
        chk({tag, ".level"}, 32'(level), 32'(lv));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(dc));
        chk({tag, ".valid"}, 32'(out_valid), 32'(lv != 0));
    endtask

    task automatic chk_rec(input string tag, input dec_vec_t v);
        chk({tag, ".instr"}, 32'(out_instr), 32'(v.dout));
        chk({tag, ".npc"}, 32'(out_npc), 32'(v.npc));
        chk({tag, ".opcode"}, 32'(out_opcode), 32'(v.op));
        chk({tag, ".dr"}, 32'(out_dr), 32'(v.dr));
        chk({tag, ".sr1"}, 32'(out_sr1), 32'(v.sr1));
        chk({tag, ".sr2"}, 32'(out_sr2), 32'(v.sr2));
        chk({tag, ".baser"}, 32'(out_baser), 32'(v.baser));
        chk({tag, ".imm5"}, 32'(out_imm5), 32'(v.imm5));
        chk({tag, ".off9"}, 32'(out_pcoffset9), 32'(v.off9));
        chk({tag, ".off6"}, 32'(out_pcoffset6), 32'(v.off6));
        chk({tag, ".nzp"}, 32'(out_nzp), 32'(v.nzp));
        chk({tag, ".middle_bit"}, 32'(out_middle_bit), 32'(v.mb));
    endtask

    task automatic chk_zero_head(input string tag);
        dec_vec_t z;
        z = '{16'h0, 16'h0, 4'h0, 3'h0, 3'h0, 3'h0, 3'h0, 5'h0, 9'h0, 6'h0, 3'h0, 1'b0};
        chk_rec(tag, z);
    endtask

    initial begin
        //          dout     npc      op    dr    sr1   sr2   baser imm5   off9     off6   nzp   mb
        vecs[0]  = '{16'h1261, 16'h3001, 4'h1, 3'd1, 3'd1, 3'd0, 3'd0, 5'd1, 9'h000, 6'h00, 3'd0, 1'b1};
        vecs[1]  = '{16'h0E05, 16'h3002, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 9'h005, 6'h00, 3'd7, 1'b0};
        vecs[2]  = '{16'h6A7F, 16'h3003, 4'h6, 3'd5, 3'd0, 3'd0, 3'd1, 5'd0, 9'h000, 6'h3F, 3'd0, 1'b0};
        vecs[3]  = '{16'h5A83, 16'h3004, 4'h5, 3'd5, 3'd2, 3'd3, 3'd0, 5'd0, 9'h000, 6'h00, 3'd0, 1'b0};
        vecs[4]  = '{16'h9A7F, 16'h3005, 4'h9, 3'd5, 3'd1, 3'd0, 3'd0, 5'd0, 9'h000, 6'h00, 3'd0, 1'b0};
        vecs[5]  = '{16'h2BFF, 16'h3006, 4'h2, 3'd5, 3'd0, 3'd0, 3'd0, 5'd0, 9'h1FF, 6'h00, 3'd0, 1'b0};
        vecs[6]  = '{16'h7C85, 16'h3007, 4'h7, 3'd0, 3'd6, 3'd0, 3'd2, 5'd0, 9'h000, 6'h05, 3'd0, 1'b0};
        vecs[7]  = '{16'hB601, 16'h3008, 4'hB, 3'd0, 3'd3, 3'd0, 3'd0, 5'd0, 9'h001, 6'h00, 3'd0, 1'b0};
        vecs[8]  = '{16'hC1C0, 16'h3009, 4'hC, 3'd0, 3'd0, 3'd0, 3'd7, 5'd0, 9'h000, 6'h00, 3'd0, 1'b0};
        vecs[9]  = '{16'hF025, 16'h300A, 4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 9'h000, 6'h00, 3'd0, 1'b0};
        vecs[10] = '{16'hE3FE, 16'h300B, 4'hE, 3'd1, 3'd0, 3'd0, 3'd0, 5'd0, 9'h1FE, 6'h00, 3'd0, 1'b0};

        reset = 1'b0;
        enable_decode = 1'b0;
        dout = 16'h0;
        npc_in = 16'h0;
        opcode_mask = 16'hFFFF;
        clear = 1'b0;
        out_ready = 1'b0;
        #2;
        chk_status("reset", 3'd0, 1'b0, 8'd0);
        chk_zero_head("reset");
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Decode table: one capture each, check head, then pop to empty.
        for (int i = 0; i < 11; i++) begin
            cap(vecs[i].dout, vecs[i].npc);
            chk_status($sformatf("dec%0d", i), 3'd1, 1'b0, 8'd0);
            chk_rec($sformatf("dec%0d", i), vecs[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("dec%0d.popped_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("dec%0d.empty_instr", i), 32'(out_instr), 32'd0);
        end

        // out_ready while empty is harmless.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_status("empty_ready", 3'd0, 1'b0, 8'd0);

        // BR then LDR back to back with the consumer always ready.
        out_ready = 1'b1;
        cap(16'h0E05, 16'h4000);
        chk_rec("br_head", '{16'h0E05, 16'h4000, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 9'h005, 6'h00, 3'd7, 1'b0});
        cap(16'h6A7F, 16'h4001);
        chk_status("ldr_follow", 3'd1, 1'b0, 8'd0);
        chk_rec("ldr_head", '{16'h6A7F, 16'h4001, 4'h6, 3'd5, 3'd0, 3'd0, 3'd1, 5'd0, 9'h000, 6'h3F, 3'd0, 1'b0});
        tick();
        out_ready = 1'b0;
        chk_status("ldr_popped", 3'd0, 1'b0, 8'd0);

        // Six captures into a 4-deep FIFO: two dropped, order preserved.
        for (int i = 0; i < 6; i++) cap(16'h1020 | 16'(i), 16'h5000 + 16'(i));
        chk_status("ovf", 3'd4, 1'b1, 8'd2);
        chk("ovf.head", 32'(out_instr), 32'h1020);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            // Stall cycle: head must stay put without out_ready.
            tick();
            if (i < 3) begin
                chk($sformatf("ovf.pop%0d_instr", i), 32'(out_instr), 32'h1021 + 32'(i));
                chk($sformatf("ovf.pop%0d_npc", i), 32'(out_npc), 32'h5001 + 32'(i));
            end else if (i == 3) begin
                chk("ovf.drained", 32'(out_valid), 32'd0);
            end
        end
        chk_status("ovf_sticky", 3'd0, 1'b1, 8'd2);
        do_clear();
        chk_status("ovf_cleared", 3'd0, 1'b0, 8'd0);

        // Full FIFO with simultaneous capture and pop.
        for (int i = 0; i < 4; i++) cap(16'h1030 | 16'(i), 16'h6000 + 16'(i));
        chk_status("full", 3'd4, 1'b0, 8'd0);
        out_ready = 1'b1;
        cap(16'h1034, 16'h6004);
        out_ready = 1'b0;
        chk_status("full_pushpop", 3'd4, 1'b0, 8'd0);
        chk("full_pushpop.head", 32'(out_instr), 32'h1031);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_drain%0d", i), 32'(out_instr), 32'h1031 + 32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk_status("full_drained", 3'd0, 1'b0, 8'd0);

        // Mask selects only ADD.
        opcode_mask = 16'h0002;
        cap(16'h1261, 16'h7000);
        cap(16'h5A83, 16'h7001);
        cap(16'h1042, 16'h7002);
        opcode_mask = 16'hFFFF;
        chk_status("mask", 3'd2, 1'b0, 8'd0);
        chk("mask.head", 32'(out_instr), 32'h1261);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mask.second", 32'(out_instr), 32'h1042);
        do_clear();

        // Drop counter saturates.
        for (int i = 0; i < 4; i++) cap(16'h1040 | 16'(i), 16'h0);
        enable_decode = 1'b1;
        dout = 16'h104F;
        repeat (300) tick();
        enable_decode = 1'b0;
        chk_status("sat", 3'd4, 1'b1, 8'hFF);
        chk("sat.head", 32'(out_instr), 32'h1040);

        // Level 3 with overflow set, then asynchronous reset mid-cycle.
        do_clear();
        for (int i = 0; i < 5; i++) cap(16'h1050 | 16'(i), 16'h8000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_status("pre_reset", 3'd3, 1'b1, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_status("async_reset", 3'd0, 1'b0, 8'd0);
        chk_zero_head("async_reset");
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk_status("post_reset", 3'd0, 1'b0, 8'd0);

        // Clear wins over a same-cycle capture.
        for (int i = 0; i < 5; i++) cap(16'h1060 | 16'(i), 16'h9000);
        chk_status("pre_clear", 3'd4, 1'b1, 8'd1);
        clear = 1'b1;
        out_ready = 1'b1;
        cap(16'h1070, 16'h9001);
        clear = 1'b0;
        out_ready = 1'b0;
        chk_status("clear_cap", 3'd0, 1'b0, 8'd0);
        cap(16'h1071, 16'h9002);
        chk_status("after_clear", 3'd1, 1'b0, 8'd0);
        chk("after_clear.head", 32'(out_instr), 32'h1071);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
